// File: rtl/reg_writeback.sv
// Write-back stage: accepts retiring instructions from MEM, waits for the
// data-memory response on loads, extracts/extends load data and issues one
// registered register-file write (and retire pulse) per instruction.
// Optional retired-instruction counter: define WB_RETIRE_CNT_EN.
module reg_writeback #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic [4:0]       in_rd_addr,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [2:0]       in_funct3,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_data,
  output logic             reg_write,
  output logic [4:0]       rd_addr,
  output logic [XLEN-1:0]  rd_data,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t          state, state_nxt;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_off;
  logic            ld_we;
  logic            capture;
  logic            done;
  logic            we_nxt;
  logic [4:0]      addr_nxt;
  logic [XLEN-1:0] data_nxt;

  // Select byte/half from the aligned word and sign- or zero-extend it
  function automatic logic [XLEN-1:0] extract(input logic [2:0]      f3,
                                              input logic [1:0]      off,
                                              input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{(XLEN-8){b[7]}}, b};
      3'b100:  extract = {{(XLEN-8){1'b0}}, b};
      3'b001:  extract = {{(XLEN-16){h[15]}}, h};
      3'b101:  extract = {{(XLEN-16){1'b0}}, h};
      default: extract = w;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, handshake and completion decode
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = in_rd_addr;
    data_nxt  = in_alu_result;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_wb_sel == 2'b01) begin
            capture   = 1'b1;
            state_nxt = LOAD_WAIT;
          end else begin
            done     = 1'b1;
            we_nxt   = in_reg_write && (in_rd_addr != 5'd0) && (in_wb_sel != 2'b11);
            data_nxt = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
          end
        end
      end
      LOAD_WAIT: begin
        addr_nxt = ld_rd;
        data_nxt = extract(ld_funct3, ld_off, mem_rsp_data);
        if (mem_rsp_valid) begin
          done      = 1'b1;
          we_nxt    = ld_we && (ld_rd != 5'd0);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold the load's destination and extraction controls while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_rd     <= '0;
      ld_funct3 <= '0;
      ld_off    <= '0;
      ld_we     <= 1'b0;
    end else if (capture) begin
      ld_rd     <= in_rd_addr;
      ld_funct3 <= in_funct3;
      ld_off    <= in_alu_result[1:0];
      ld_we     <= in_reg_write;
    end
  end

  // Registered write port; address/data hold when nothing completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write <= 1'b0;
      retire    <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else begin
      reg_write <= done && we_nxt;
      retire    <= done;
      if (done) begin
        rd_addr <= addr_nxt;
        rd_data <= data_nxt;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Count completions; advances on the same edge that raises retire
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (done) cnt <= cnt + CNT_W'(1);
  end

  assign retire_count = cnt;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: a per-instruction model predicts the
// write port every cycle, plus literal expectations from hand calculation.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_reg_write = 1'b0;
  logic [4:0]  in_rd_addr = '0;
  logic [1:0]  in_wb_sel = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_pc_plus4 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        retire;
  logic [63:0] retire_count;

  int vectors = 0;
  int miscompares = 0;

  reg_writeback #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_funct3(in_funct3),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .retire(retire), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pending;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  bit          m_we_req;
  bit          e_we, e_ret;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  logic [63:0] e_cnt;

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> (8 * int'(off));
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b100:  return 32'(sh[7:0]);
      3'b001:  begin sh = word >> (off[1] ? 16 : 0); return 32'($signed(sh[15:0])); end
      3'b101:  begin sh = word >> (off[1] ? 16 : 0); return 32'(sh[15:0]); end
      default: return word;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pending <= 0; e_we <= 0; e_ret <= 0; e_rd <= '0; e_data <= '0; e_cnt <= '0;
    end else begin
      e_we  <= 0;
      e_ret <= 0;
      if (!m_pending) begin
        if (in_valid && in_wb_sel == 2'b01) begin
          m_pending <= 1; m_rd <= in_rd_addr; m_f3 <= in_funct3;
          m_off <= in_alu_result[1:0]; m_we_req <= in_reg_write;
        end else if (in_valid) begin
          e_ret  <= 1;
          e_we   <= in_reg_write && in_rd_addr != 0 && in_wb_sel != 2'b11;
          e_rd   <= in_rd_addr;
          e_data <= (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
          e_cnt  <= e_cnt + 1;
        end
      end else if (mem_rsp_valid) begin
        m_pending <= 0;
        e_ret  <= 1;
        e_we   <= m_we_req && m_rd != 0;
        e_rd   <= m_rd;
        e_data <= load_value(m_f3, m_off, mem_rsp_data);
        e_cnt  <= e_cnt + 1;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    check("in_ready", 64'(in_ready), 64'(!m_pending));
    check("reg_write", 64'(reg_write), 64'(e_we));
    check("retire", 64'(retire), 64'(e_ret));
    check("rd_addr", 64'(rd_addr), 64'(e_rd));
    check("rd_data", 64'(rd_data), 64'(e_data));
`ifdef WB_RETIRE_CNT_EN
    check("retire_count", retire_count, e_cnt);
`else
    check("retire_count", retire_count, 64'd0);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] f3, input logic rw);
    in_valid = 1'b1; in_wb_sel = sel; in_rd_addr = rd; in_alu_result = alu;
    in_pc_plus4 = pc4; in_funct3 = f3; in_reg_write = rw;
  endtask

  // Single non-load: accept at next edge, then check the write pulse
  task automatic alu_op(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] v,
                        input logic rw, input logic exp_we, input string tag);
    drive(sel, rd, v, v, 3'b000, rw);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".we"}, 64'(reg_write), 64'(exp_we));
    check({tag, ".retire"}, 64'(retire), 64'd1);
    check({tag, ".addr"}, 64'(rd_addr), 64'(rd));
    @(posedge clk); #1;
  endtask

  // Load: wait three cycles with in_valid held high, then respond
  task automatic load_op(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] word,
                         input logic rw, input logic [31:0] exp_data, input logic exp_we,
                         input string tag);
    drive(2'b01, 5'd7, alu, 32'h0, f3, rw);
    @(posedge clk); #1 drive(2'b00, 5'd9, 32'hDEAD, 32'h0, 3'b000, 1'b1);
    @(negedge clk);
    check({tag, ".busy"}, 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 mem_rsp_valid = 1'b1; mem_rsp_data = word; in_valid = 1'b0;
    @(posedge clk); #1 mem_rsp_valid = 1'b0;
    @(negedge clk);
    check({tag, ".data"}, 64'(rd_data), 64'(exp_data));
    check({tag, ".we"}, 64'(reg_write), 64'(exp_we));
    check({tag, ".retire"}, 64'(retire), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.we", 64'(reg_write), 64'd0);
    check("rst.data", 64'(rd_data), 64'd0);
    check("rst.cnt", retire_count, 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // ALU op with literal expectations
    drive(2'b00, 5'd5, 32'h0000_00A5, 32'h0, 3'b000, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("alu.we", 64'(reg_write), 64'd1);
    check("alu.addr", 64'(rd_addr), 64'd5);
    check("alu.data", 64'(rd_data), 64'h0000_00A5);
    check("alu.retire", 64'(retire), 64'd1);
    @(negedge clk);
    check("alu.pulse_end", 64'(reg_write), 64'd0);
    check("alu.hold", 64'(rd_data), 64'h0000_00A5);
    @(posedge clk); #1;

    // Back-to-back ALU then PC+4
    drive(2'b00, 5'd3, 32'h11, 32'h0, 3'b000, 1'b1);
    @(posedge clk); #1 drive(2'b10, 5'd4, 32'h55, 32'h104, 3'b000, 1'b1);
    @(negedge clk);
    check("b2b.ready", 64'(in_ready), 64'd1);
    check("b2b.first", 64'({reg_write, rd_addr, rd_data}), {26'd0, 1'b1, 5'd3, 32'h11});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b.second", 64'({reg_write, rd_addr, rd_data}), {26'd0, 1'b1, 5'd4, 32'h104});
    @(posedge clk); #1;

    // Loads
    load_op(3'b000, 32'h1002, 32'h1280_FF00, 1'b1, 32'hFFFF_FF80, 1'b1, "lb");
    load_op(3'b100, 32'h1002, 32'h1280_FF00, 1'b1, 32'h0000_0080, 1'b1, "lbu");
    load_op(3'b001, 32'h1002, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001, 1'b1, "lh");
    load_op(3'b101, 32'h1002, 32'h8001_7FFF, 1'b1, 32'h0000_8001, 1'b1, "lhu");
    load_op(3'b001, 32'h1000, 32'h8001_7FFF, 1'b1, 32'h0000_7FFF, 1'b1, "lh_lo");
    load_op(3'b000, 32'h1003, 32'h7F00_0000, 1'b1, 32'h0000_007F, 1'b1, "lb_top");
    load_op(3'b010, 32'h1000, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, "lw");
    load_op(3'b011, 32'h1001, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, "f3_011");
    load_op(3'b010, 32'h1000, 32'hAAAA_5555, 1'b0, 32'hAAAA_5555, 1'b0, "ld_nowr");

    // Non-writing retirements
    alu_op(2'b00, 5'd0, 32'h77, 1'b1, 1'b0, "x0");
    alu_op(2'b00, 5'd6, 32'h78, 1'b0, 1'b0, "rw0");
    alu_op(2'b11, 5'd8, 32'h79, 1'b1, 1'b0, "sel11");

    // Stray response in IDLE
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
    @(posedge clk); #1 mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stray.we", 64'(reg_write), 64'd0);
    check("stray.retire", 64'(retire), 64'd0);
    @(posedge clk); #1;

    // Reset mid-load, then a late response must be ignored
    drive(2'b01, 5'd10, 32'h2000, 32'h0, 3'b010, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstld.addr", 64'(rd_addr), 64'd0);
    check("rstld.data", 64'(rd_data), 64'd0);
    check("rstld.cnt", retire_count, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1357_9BDF;
    @(posedge clk); #1 mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("rstld.we", 64'(reg_write), 64'd0);
    check("rstld.retire", 64'(retire), 64'd0);
    check("rstld.ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Five retirements after reset
    for (int i = 0; i < 5; i++)
      alu_op(2'b00, 5'(i + 1), 32'(i * 3), 1'b1, 1'b1, "cnt");
    @(negedge clk);
`ifdef WB_RETIRE_CNT_EN
    check("cnt.five", retire_count, 64'd5);
`else
    check("cnt.tied", retire_count, 64'd0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
Write-back stage that drives the register file's write port (reg_write, rd_addr, rd_data).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- Waits for the data-memory response on loads and sign- or zero-extends load data.
- Selects the write-back source and issues exactly one registered write pulse per instruction.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
CNT_W, 64, width of the retired-instruction counter (optional feature only).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
in_valid  in  1  MEM stage presents an instruction.
in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge.
in_reg_write  in  1  instruction writes rd.
in_rd_addr  in  5  destination register.
in_wb_sel  in  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved.
in_alu_result  in  XLEN  ALU result; its low 2 bits are the load byte offset.
in_pc_plus4  in  XLEN  link value for JAL/JALR.
in_funct3  in  3  load size/sign (RV32I encoding).
mem_rsp_valid  in  1  data-memory read response valid (single-cycle pulse).
mem_rsp_data  in  XLEN  aligned 32-bit word read from memory.
reg_write  out  1  write enable to register file.
rd_addr  out  5  write address to register file.
rd_data  out  XLEN  write data to register file.
retire  out  1  one-cycle pulse per completed instruction.
retire_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; reg_write=0, rd_addr=0, rd_data=0, retire=0, retire_count=0.
  - Any pending load is discarded; a later mem_rsp_valid for it is ignored.
- FSM states: IDLE, LOAD_WAIT.
  - IDLE: in_ready=1.
    - Accept with wb_sel=01 → capture rd/funct3/offset/reg_write, go to LOAD_WAIT.
    - Accept with any other wb_sel → stay in IDLE; outputs update on that same edge.
  - LOAD_WAIT: in_ready=0.
    - mem_rsp_valid=1 → outputs update on that edge, go to IDLE.
    - No timeout.
- Latency:
  - Non-load accepted at edge N → reg_write/retire high in cycle N..N+1, i.e. visible for exactly one cycle after edge N.
  - Throughput is 1 instruction/cycle for non-loads.
  - Load: write is visible the cycle after the edge that samples mem_rsp_valid. Minimum 2-cycle occupancy, and no new instruction is accepted until the response arrives.
- Write enable:
  - reg_write = captured in_reg_write && rd_addr!=0 && wb_sel!=11.
  - rd_addr and rd_data are still driven when reg_write=0.
  - retire pulses for every completed instruction, including wb_sel=11 and rd=x0.
- Outputs are registered. When nothing completes, reg_write=0 and retire=0; rd_addr and rd_data hold their last values.
- Load extraction, using off = alu_result[1:0]:
  - LB (000): byte at 8*off, sign-extended.
  - LBU (100): byte at 8*off, zero-extended.
  - LH (001): half at 16*off[1], sign-extended.
  - LHU (101): half at 16*off[1], zero-extended.
  - LW (010) and all other funct3: raw word.
- mem_rsp_valid in IDLE is ignored: no write, no retire.
- A load with in_reg_write=0 still waits for its response, then retires without writing.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined: retire_count increments by 1 on each retire pulse, wrapping modulo 2^CNT_W, and is cleared only by reset.
- Undefined: no counter is instantiated and retire_count is tied to 0; the port list is unchanged.

Test Plan:
- ALU op: in_valid=1, wb_sel=00, rd=5, alu=0x0000_00A5, reg_write=1 → next cycle reg_write=1, rd_addr=5, rd_data=0x0000_00A5, retire=1, for one cycle.
- Back-to-back: rd=3 ALU=0x11 then rd=4 PC+4=0x104 on consecutive cycles, in_ready stays 1 → two consecutive write pulses (3,0x11) then (4,0x104).
- LB sign: funct3=000, alu=0x1002 (off=2), rsp after 3 cycles with data 0x1280_FF00 → in_ready=0 while waiting; then rd_data=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- LH/LHU: off=2, data 0x8001_7FFF → LH 0xFFFF_8001, LHU 0x0000_8001.
- rd=x0 / reg_write=0: wb_sel=00, rd=0 → reg_write=0, retire=1. Stray mem_rsp_valid in IDLE → no reg_write, no retire.
- Reset mid-load: accept load, drop rst to 0 before the response, release, then pulse mem_rsp_valid → all outputs 0, no write. With WB_RETIRE_CNT_EN, retire_count=0 after reset and equals 5 after 5 retirements.
